// File: rtl/cm0_reset_ctrl.sv
// -----------------------------------------------------------------------------
// cm0_reset_ctrl
//
// Reset sequencer that sits downstream of the per-domain reset synchronisers.
// After a power-on reset it releases the debug domain first. It then releases
// the system domain after a further hold. It also converts core reset requests
// (SYSRESETREQ, and LOCKUP when LOCKUPRESET is set) into a stretched reset that
// affects only the system domain. The debug domain keeps running.
//
// Parameters
//   DBG_HOLD  cycles DBGRESETn stays low after RST deasserts (1..2^CW-1)
//   SYS_HOLD  cycles SYSRESETn stays low after debug release / per request
//   CW        hold counter width
//
// Ports
//   CLK          in   clock
//   RST          in   synchronous active-high reset (synchronised POR)
//   SYSRESETREQ  in   core system reset request, level
//   LOCKUP       in   core lockup indication, level
//   LOCKUPRESET  in   1 = lockup triggers a system reset
//   CAUSECLR     in   1-cycle pulse, clears RSTCAUSE
//   DBGRESETn    out  debug-domain reset, active low, registered
//   SYSRESETn    out  system-domain reset, active low, registered
//   RSTBUSY      out  high while either domain is held in reset
//   RSTCAUSE     out  {lockup, sysreq, por}, sticky
//
// Configuration
//   CM0_RSTCTRL_CAUSE_EN  when defined, RSTCAUSE is a sticky cause register.
//                         When undefined, RSTCAUSE is tied to 3'b000 and
//                         CAUSECLR is ignored.
// -----------------------------------------------------------------------------
module cm0_reset_ctrl #(
    parameter int DBG_HOLD = 4,
    parameter int SYS_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SYSRESETREQ,
    input  logic       LOCKUP,
    input  logic       LOCKUPRESET,
    input  logic       CAUSECLR,
    output logic       DBGRESETn,
    output logic       SYSRESETn,
    output logic       RSTBUSY,
    output logic [2:0] RSTCAUSE
);

    typedef enum logic [1:0] {
        POR_HOLD = 2'd0,
        DBG_ONLY = 2'd1,
        RUN      = 2'd2,
        SYS_RST  = 2'd3
    } state_t;

    localparam logic [CW-1:0] DBG_LAST = CW'(DBG_HOLD - 1);
    localparam logic [CW-1:0] SYS_LAST = CW'(SYS_HOLD - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          dbg_resetn_d, sys_resetn_d, rst_busy_d;
    logic          req_now, req_prev, trig;

    // A request is a rising edge of the combined level. req_prev is forced
    // high by RST, so a level that is held across reset never triggers.
    assign req_now = SYSRESETREQ | (LOCKUP & LOCKUPRESET);
    assign trig    = req_now & ~req_prev;

    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // the values from before the edge, whatever order the statements are in.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= POR_HOLD;
            cnt       <= '0;
            DBGRESETn <= 1'b0;
            SYSRESETn <= 1'b0;
            RSTBUSY   <= 1'b1;
            req_prev  <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            DBGRESETn <= dbg_resetn_d;
            SYSRESETn <= sys_resetn_d;
            RSTBUSY   <= rst_busy_d;
            req_prev  <= req_now;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case. If any path left
        // one unassigned, a latch would be inferred.
        state_d      = state;
        cnt_d        = cnt;
        dbg_resetn_d = DBGRESETn;
        sys_resetn_d = SYSRESETn;
        rst_busy_d   = RSTBUSY;

        case (state)
            POR_HOLD: begin
                dbg_resetn_d = 1'b0;
                sys_resetn_d = 1'b0;
                rst_busy_d   = 1'b1;
                if (cnt == DBG_LAST) begin
                    cnt_d        = '0;
                    dbg_resetn_d = 1'b1;
                    state_d      = DBG_ONLY;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            DBG_ONLY: begin
                if (cnt == SYS_LAST) begin
                    cnt_d        = '0;
                    sys_resetn_d = 1'b1;
                    rst_busy_d   = 1'b0;
                    state_d      = RUN;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            RUN: begin
                if (trig) begin
                    cnt_d        = '0;
                    sys_resetn_d = 1'b0;
                    rst_busy_d   = 1'b1;
                    state_d      = SYS_RST;
                end
            end

            SYS_RST: begin
                // Edges seen here are dropped, not queued. The debug domain
                // is left alone.
                if (cnt == SYS_LAST) begin
                    cnt_d        = '0;
                    sys_resetn_d = 1'b1;
                    rst_busy_d   = 1'b0;
                    state_d      = RUN;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            default: begin
                // Corrupted state: start the full sequence again.
                state_d      = POR_HOLD;
                cnt_d        = '0;
                dbg_resetn_d = 1'b0;
                sys_resetn_d = 1'b0;
                rst_busy_d   = 1'b1;
            end
        endcase
    end

`ifdef CM0_RSTCTRL_CAUSE_EN
    logic       accept;
    logic [2:0] cause_set;
    logic [2:0] cause_q;

    // Only requests that actually start a system reset are recorded.
    assign accept    = (state == RUN) & trig;
    assign cause_set = accept ? {LOCKUP & LOCKUPRESET, SYSRESETREQ, 1'b0} : 3'b000;

    // A clear in the same cycle as a set keeps only the new cause.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cause_q <= 3'b001;
        end else if (CAUSECLR) begin
            cause_q <= cause_set;
        end else begin
            cause_q <= cause_q | cause_set;
        end
    end

    assign RSTCAUSE = cause_q;
`else
    logic unused_causeclr;

    assign unused_causeclr = CAUSECLR;
    assign RSTCAUSE        = 3'b000;
`endif

endmodule

// File: tb/tb_cm0_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cm0_reset_ctrl
//
// Self-checking bench for cm0_reset_ctrl with the default parameters
// (DBG_HOLD=4, SYS_HOLD=8). It uses a table of per-cycle vectors for power-on
// sequencing and the basic request handling. It uses hand-written sequences
// for the multi-cycle corner cases: dropped edges, RST during SYS_RST and
// DBG_ONLY, clear/set collisions and requests held across reset.
// Each vector drives inputs on the falling edge. It then compares
// {DBGRESETn, SYSRESETn, RSTBUSY, RSTCAUSE} 1 ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_cm0_reset_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SYSRESETREQ = 1'b0;
    logic       LOCKUP = 1'b0;
    logic       LOCKUPRESET = 1'b0;
    logic       CAUSECLR = 1'b0;
    logic       DBGRESETn;
    logic       SYSRESETn;
    logic       RSTBUSY;
    logic [2:0] RSTCAUSE;

    always #5 CLK = ~CLK;

    cm0_reset_ctrl #(
        .DBG_HOLD(4),
        .SYS_HOLD(8),
        .CW      (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SYSRESETREQ(SYSRESETREQ),
        .LOCKUP     (LOCKUP),
        .LOCKUPRESET(LOCKUPRESET),
        .CAUSECLR   (CAUSECLR),
        .DBGRESETn  (DBGRESETn),
        .SYSRESETn  (SYSRESETn),
        .RSTBUSY    (RSTBUSY),
        .RSTCAUSE   (RSTCAUSE)
    );

    // exp packs {DBGRESETn, SYSRESETn, RSTBUSY, RSTCAUSE[2:0]}
    typedef struct {
        logic       rst;
        logic       sreq;
        logic       lk;
        logic       lkr;
        logic       clr;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // The cause register only exists in the CAUSE_EN build.
    function automatic logic [2:0] ce(input logic [2:0] c);
`ifdef CM0_RSTCTRL_CAUSE_EN
        return c;
`else
        return 3'b000;
`endif
    endfunction

    function automatic logic [5:0] ex(input logic d, input logic s, input logic b,
                                      input logic [2:0] c);
        return {d, s, b, ce(c)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic sreq, input logic lk,
                                input logic lkr, input logic clr, input logic [5:0] exp);
        vec_t v;
        v.rst  = rst;
        v.sreq = sreq;
        v.lk   = lk;
        v.lkr  = lkr;
        v.clr  = clr;
        v.exp  = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got dbg/sys/busy/cause=%b_%b_%b_%b required %b_%b_%b_%b",
                     name, act[5], act[4], act[3], act[2:0],
                     exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge CLK);
        RST         = v.rst;
        SYSRESETREQ = v.sreq;
        LOCKUP      = v.lk;
        LOCKUPRESET = v.lkr;
        CAUSECLR    = v.clr;
        @(posedge CLK);
        #1;
        check(name, {DBGRESETn, SYSRESETn, RSTBUSY, RSTCAUSE}, v.exp);
    endtask

    task automatic add_n(input int n, input logic rst, input logic sreq, input logic lk,
                         input logic lkr, input logic clr, input logic [5:0] exp);
        for (int i = 0; i < n; i++) vecs.push_back(mk(rst, sreq, lk, lkr, clr, exp));
    endtask

    task automatic run_n(input int n, input string name, input logic rst, input logic sreq,
                         input logic lk, input logic lkr, input logic clr,
                         input logic [5:0] exp);
        for (int i = 0; i < n; i++)
            apply(mk(rst, sreq, lk, lkr, clr, exp), $sformatf("%s[%0d]", name, i));
    endtask

    // After RST drops: 3 cycles fully held, debug up on the 4th edge,
    // 7 further debug-only cycles, system up on the 8th edge after that.
    task automatic run_por_release(input string name, input logic sreq, input logic [2:0] c);
        run_n(3, {name, "_por"},    1'b0, sreq, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b1, c));
        run_n(1, {name, "_dbgup"},  1'b0, sreq, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b1, c));
        run_n(7, {name, "_dbgonly"},1'b0, sreq, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b1, c));
        run_n(1, {name, "_sysup"},  1'b0, sreq, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b1, 1'b0, c));
    endtask

    initial begin
        // ---------------- table: power-on sequence ----------------
        add_n(3, 1, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));   // RST held
        add_n(3, 0, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));   // POR_HOLD
        add_n(1, 0, 0, 0, 0, 0, ex(1, 0, 1, 3'b001));   // debug released
        add_n(7, 0, 0, 0, 0, 0, ex(1, 0, 1, 3'b001));   // DBG_ONLY
        add_n(1, 0, 0, 0, 0, 0, ex(1, 1, 0, 3'b001));   // system released
        add_n(3, 0, 0, 0, 0, 0, ex(1, 1, 0, 3'b001));   // RUN idle
        // ---------------- table: SYSRESETREQ held 20 cycles ----------------
        add_n(8,  0, 1, 0, 0, 0, ex(1, 0, 1, 3'b011));
        add_n(12, 0, 1, 0, 0, 0, ex(1, 1, 0, 3'b011));  // no retrigger
        add_n(2,  0, 0, 0, 0, 0, ex(1, 1, 0, 3'b011));
        // ---------------- table: lockup gating ----------------
        add_n(5, 0, 0, 1, 0, 0, ex(1, 1, 0, 3'b011));   // LOCKUPRESET=0: ignored
        add_n(1, 0, 0, 0, 0, 1, ex(1, 1, 0, 3'b000));   // clear cause
        add_n(8, 0, 0, 1, 1, 0, ex(1, 0, 1, 3'b100));   // lockup reset
        add_n(3, 0, 0, 1, 1, 0, ex(1, 1, 0, 3'b100));
        add_n(1, 0, 0, 0, 1, 0, ex(1, 1, 0, 3'b100));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // ---------------- second edge during SYS_RST is dropped ----------------
        run_n(1, "t4_edge1", 0, 1, 0, 0, 0, ex(1, 0, 1, 3'b110));
        run_n(1, "t4_low",   0, 0, 0, 0, 0, ex(1, 0, 1, 3'b110));
        run_n(1, "t4_edge2", 0, 1, 0, 0, 0, ex(1, 0, 1, 3'b110));
        run_n(5, "t4_hold",  0, 0, 0, 0, 0, ex(1, 0, 1, 3'b110));
        run_n(6, "t4_run",   0, 0, 0, 0, 0, ex(1, 1, 0, 3'b110));

        // ---------------- RST mid-SYS_RST, edge dropped in DBG_ONLY ----------------
        run_n(1, "t5_req",   0, 1, 0, 0, 0, ex(1, 0, 1, 3'b110));
        run_n(4, "t5_sys",   0, 0, 0, 0, 0, ex(1, 0, 1, 3'b110));
        run_n(1, "t5_rst",   1, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));
        run_n(3, "t5_por",   0, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));
        run_n(1, "t5_dbgup", 0, 0, 0, 0, 0, ex(1, 0, 1, 3'b001));
        run_n(1, "t5_dbg0",  0, 0, 0, 0, 0, ex(1, 0, 1, 3'b001));
        run_n(6, "t5_dbgrq", 0, 1, 0, 0, 0, ex(1, 0, 1, 3'b001));
        run_n(1, "t5_sysup", 0, 1, 0, 0, 0, ex(1, 1, 0, 3'b001));
        run_n(3, "t5_noret", 0, 1, 0, 0, 0, ex(1, 1, 0, 3'b001));
        run_n(2, "t5_idle",  0, 0, 0, 0, 0, ex(1, 1, 0, 3'b001));

        // ---------------- CAUSECLR coincident with request edge ----------------
        run_n(1, "t6_clrset", 0, 1, 0, 0, 1, ex(1, 0, 1, 3'b010));
        run_n(7, "t6_sys",    0, 1, 0, 0, 0, ex(1, 0, 1, 3'b010));
        run_n(1, "t6_up",     0, 1, 0, 0, 0, ex(1, 1, 0, 3'b010));
        run_n(2, "t6_idle",   0, 0, 0, 0, 0, ex(1, 1, 0, 3'b010));

        // ---------------- request held high across RST release ----------------
        run_n(2, "t6_rst", 1, 1, 0, 0, 0, ex(0, 0, 1, 3'b001));
        run_por_release("t6_held", 1'b1, 3'b001);
        run_n(10, "t6_noreq", 0, 1, 0, 0, 0, ex(1, 1, 0, 3'b001));
        run_n(1,  "t6_drop",  0, 0, 0, 0, 0, ex(1, 1, 0, 3'b001));
        run_n(1,  "t6_again", 0, 1, 0, 0, 0, ex(1, 0, 1, 3'b011));
        run_n(7,  "t6_again", 0, 1, 0, 0, 0, ex(1, 0, 1, 3'b011));
        run_n(1,  "t6_again", 0, 0, 0, 0, 0, ex(1, 1, 0, 3'b011));

        // ---------------- RST mid-DBG_ONLY ----------------
        run_n(1, "t7_rst",   1, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));
        run_n(3, "t7_por",   0, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));
        run_n(1, "t7_dbgup", 0, 0, 0, 0, 0, ex(1, 0, 1, 3'b001));
        run_n(3, "t7_dbg",   0, 0, 0, 0, 0, ex(1, 0, 1, 3'b001));
        run_n(1, "t7_rst2",  1, 0, 0, 0, 0, ex(0, 0, 1, 3'b001));
        run_por_release("t7_rel", 1'b0, 3'b001);

        // ---------------- both request sources rise together ----------------
        run_n(1, "t8_both", 0, 1, 1, 1, 0, ex(1, 0, 1, 3'b111));
        run_n(7, "t8_sys",  0, 1, 1, 1, 0, ex(1, 0, 1, 3'b111));
        run_n(1, "t8_up",   0, 0, 0, 0, 0, ex(1, 1, 0, 3'b111));
        run_n(2, "t8_idle", 0, 0, 0, 0, 0, ex(1, 1, 0, 3'b111));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
